wptr_full_handler: RTL and testbench

WPTR_FULL_HANDLER -- requirements
Module: wptr_full_handler

---
 rtl/wptr_full_handler.sv | 170 +++++++++++++++++
 tb/tb_wptr_full_handler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_handler.sv
// -----------------------------------------------------------------------------
// wptr_full_handler
//
// Write-side pointer and status logic for an asynchronous FIFO. Holds the
// binary and Gray write pointers, derives the full / almost-full flags and the
// write-side fill level from the Gray read pointer that has already been
// synchronized into the write clock domain, and tracks writes that were
// rejected because the FIFO was full.
//
// Parameters
//   PTR_WIDTH  address width; FIFO depth is 2**PTR_WIDTH
//   AF_MARGIN  almost-full asserts when AF_MARGIN or fewer slots are free
//              (legal range 1..DEPTH-1)
//   OVF_CNT_W  width of the saturating rejected-write counter
//
// Ports
//   i_Wclk         write-domain clock, all state changes on its rising edge
//   i_Wrst_n       asynchronous active-low reset (release synchronized outside)
//   i_W_en         write request from the producer
//   i_g_rptr_sync  Gray read pointer, already synchronized into i_Wclk domain
//   i_clr_ovf      clears the overflow flag and counter on the next edge
//   o_mem_we       memory write strobe (combinational: i_W_en & ~o_full)
//   o_b_wptr       registered binary write pointer; low bits address memory
//   o_g_wptr       registered Gray write pointer, sent to the read domain
//   o_full         registered full flag
//   o_almost_full  registered almost-full flag
//   o_wlevel       registered fill level seen from the write side, 0..DEPTH
//   o_overflow     sticky flag: a write was attempted while full
//   o_ovf_cnt      saturating count of rejected writes
// -----------------------------------------------------------------------------
module wptr_full_handler #(
    parameter int unsigned PTR_WIDTH = 3,
    parameter int unsigned AF_MARGIN = 2,
    parameter int unsigned OVF_CNT_W = 8
) (
    input  logic                 i_Wclk,
    input  logic                 i_Wrst_n,
    input  logic                 i_W_en,
    input  logic [PTR_WIDTH:0]   i_g_rptr_sync,
    input  logic                 i_clr_ovf,
    output logic                 o_mem_we,
    output logic [PTR_WIDTH:0]   o_b_wptr,
    output logic [PTR_WIDTH:0]   o_g_wptr,
    output logic                 o_full,
    output logic                 o_almost_full,
    output logic [PTR_WIDTH:0]   o_wlevel,
    output logic                 o_overflow,
    output logic [OVF_CNT_W-1:0] o_ovf_cnt
);

    // Pointers carry one extra wrap bit above the address bits so that
    // "full" and "empty" (same address) can be told apart.
    localparam int unsigned PW    = PTR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << PTR_WIDTH;

    // Full when the write pointer is exactly one lap ahead of the read
    // pointer. In Gray code that means the two MSBs differ and every lower
    // bit matches, so the comparison mask flips only the top two bits.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    // Level at and above which almost-full asserts.
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    logic [PW-1:0]        b_wptr_q;
    logic [PW-1:0]        g_wptr_q;
    logic                 full_q;
    logic                 almost_full_q;
    logic [PW-1:0]        wlevel_q;
    logic                 overflow_q;
    logic [OVF_CNT_W-1:0] ovf_cnt_q;

    // -------------------------------------------------------------------------
    // Next-state values
    // -------------------------------------------------------------------------
    logic                 mem_we;
    logic                 write_rejected;
    logic [PW-1:0]        b_wptr_d;
    logic [PW-1:0]        g_wptr_d;
    logic [PW-1:0]        rbin;
    logic                 full_d;
    logic [PW-1:0]        wlevel_d;
    logic                 almost_full_d;
    logic                 overflow_d;
    logic [OVF_CNT_W-1:0] ovf_cnt_d;

    // A write is accepted only while the registered full flag is low; this is
    // what guarantees unread data is never overwritten. Because the read
    // pointer seen here lags the real one, full can only be reported late in
    // the "draining" direction, never early in the "filling" direction.
    assign mem_we         = i_W_en & ~full_q;
    assign write_rejected = i_W_en &  full_q;

    // Pointer advance and binary-to-Gray conversion.
    assign b_wptr_d = b_wptr_q + {{(PW-1){1'b0}}, mem_we};
    assign g_wptr_d = (b_wptr_d >> 1) ^ b_wptr_d;

    // Gray-to-binary of the synchronized read pointer: each binary bit is the
    // XOR of all Gray bits at and above its position.
    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < int'(PW); i++) begin
            rbin[i] = ^(i_g_rptr_sync >> i);
        end
    end

    // Full, level and almost-full are all computed from the pointer value that
    // is about to be loaded, so the flags line up with the registered pointer.
    assign full_d        = (g_wptr_d == (i_g_rptr_sync ^ FULL_MASK));
    assign wlevel_d      = b_wptr_d - rbin;
    assign almost_full_d = (wlevel_d >= AF_LEVEL);

    // Overflow tracking. A clear in the same cycle as a rejected write wins,
    // and the counter holds at all-ones instead of wrapping back to zero.
    always_comb begin
        overflow_d = overflow_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (i_clr_ovf) begin
            overflow_d = 1'b0;
            ovf_cnt_d  = '0;
        end else if (write_rejected) begin
            overflow_d = 1'b1;
            if (!(&ovf_cnt_q)) begin
                ovf_cnt_d = ovf_cnt_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so that
    // every register samples the pre-edge values of the others.
    always_ff @(posedge i_Wclk or negedge i_Wrst_n) begin
        if (!i_Wrst_n) begin
            b_wptr_q      <= '0;
            g_wptr_q      <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            wlevel_q      <= '0;
            overflow_q    <= 1'b0;
            ovf_cnt_q     <= '0;
        end else begin
            b_wptr_q      <= b_wptr_d;
            g_wptr_q      <= g_wptr_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            wlevel_q      <= wlevel_d;
            overflow_q    <= overflow_d;
            ovf_cnt_q     <= ovf_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_mem_we      = mem_we;
    assign o_b_wptr      = b_wptr_q;
    assign o_g_wptr      = g_wptr_q;
    assign o_full        = full_q;
    assign o_almost_full = almost_full_q;
    assign o_wlevel      = wlevel_q;
    assign o_overflow    = overflow_q;
    assign o_ovf_cnt     = ovf_cnt_q;

endmodule

// File: tb/tb_wptr_full_handler.sv
// -----------------------------------------------------------------------------
// tb_wptr_full_handler
//
// Drives two instances of wptr_full_handler from the same stimulus: one with
// default parameters and one with a 2-bit overflow counter. The reference
// model keeps plain integer counts of accepted writes and of reads made
// visible to the write side; pointers, flags and level follow from those by
// arithmetic. Directed sequences cover fill-to-full, rejected writes, clear
// priority, release from full, counter saturation and asynchronous reset;
// a randomized phase exercises pointer wrap and interleaved traffic.
// -----------------------------------------------------------------------------
module tb_wptr_full_handler;

    localparam int PW    = 4;
    localparam int DEPTH = 8;
    localparam int AFM   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w_en = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] rptr = '0;

    logic       mem_we,  mem_we2;
    logic [3:0] b_wptr,  b_wptr2;
    logic [3:0] g_wptr,  g_wptr2;
    logic       full,    full2;
    logic       af,      af2;
    logic [3:0] wlevel,  wlevel2;
    logic       ovf,     ovf2;
    logic [7:0] ovf_cnt;
    logic [1:0] ovf_cnt2;

    wptr_full_handler #(.PTR_WIDTH(3), .AF_MARGIN(AFM), .OVF_CNT_W(8)) dut (
        .i_Wclk(clk), .i_Wrst_n(rst_n), .i_W_en(w_en), .i_g_rptr_sync(rptr),
        .i_clr_ovf(clr), .o_mem_we(mem_we), .o_b_wptr(b_wptr), .o_g_wptr(g_wptr),
        .o_full(full), .o_almost_full(af), .o_wlevel(wlevel),
        .o_overflow(ovf), .o_ovf_cnt(ovf_cnt)
    );

    wptr_full_handler #(.PTR_WIDTH(3), .AF_MARGIN(AFM), .OVF_CNT_W(2)) dut2 (
        .i_Wclk(clk), .i_Wrst_n(rst_n), .i_W_en(w_en), .i_g_rptr_sync(rptr),
        .i_clr_ovf(clr), .o_mem_we(mem_we2), .o_b_wptr(b_wptr2), .o_g_wptr(g_wptr2),
        .o_full(full2), .o_almost_full(af2), .o_wlevel(wlevel2),
        .o_overflow(ovf2), .o_ovf_cnt(ovf_cnt2)
    );

    always #5 clk = ~clk;

    // Reference model state
    int   wcount;   // writes accepted since reset
    int   rcount;   // reads visible to the write side since reset
    int   m_rej;    // rejected writes since last clear
    bit   m_ovf;
    bit   m_full;
    logic [3:0] prev_g;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] to_gray(input int n);
        logic [3:0] b;
        b = 4'(n % 16);
        return b ^ (b >> 1);
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        wcount = 0;
        rcount = 0;
        m_rej  = 0;
        m_ovf  = 1'b0;
        m_full = 1'b0;
        prev_g = '0;
    endtask

    // Compare every registered output of both instances against the model.
    task automatic check_all(input string tag);
        int lvl;
        lvl = wcount - rcount;
        check({tag, ".b_wptr"},   32'(b_wptr),   32'(wcount % 16));
        check({tag, ".g_wptr"},   32'(g_wptr),   32'(to_gray(wcount)));
        check({tag, ".full"},     32'(full),     32'(lvl == DEPTH));
        check({tag, ".af"},       32'(af),       32'(lvl >= DEPTH - AFM));
        check({tag, ".wlevel"},   32'(wlevel),   32'(lvl));
        check({tag, ".ovf"},      32'(ovf),      32'(m_ovf));
        check({tag, ".ovf_cnt"},  32'(ovf_cnt),  32'(sat(m_rej, 255)));
        check({tag, ".ovf_cnt2"}, 32'(ovf_cnt2), 32'(sat(m_rej, 3)));
        check({tag, ".full2"},    32'(full2),    32'(lvl == DEPTH));
        check({tag, ".g_hamming"}, 32'($countones(g_wptr ^ prev_g) <= 1), 32'd1);
        prev_g = g_wptr;
    endtask

    // One clock cycle: apply inputs, check the combinational strobe, advance
    // the model, then check registered outputs just after the edge.
    task automatic step(input bit w, input bit rd, input bit c, input string tag);
        bit accept;
        w_en = w;
        clr  = c;
        if (rd && rcount < wcount) rcount++;
        rptr = to_gray(rcount);
        #1;
        check({tag, ".mem_we"}, 32'(mem_we), 32'(w && !m_full));
        accept = w && !m_full;
        if (c) begin
            m_ovf = 1'b0;
            m_rej = 0;
        end else if (w && m_full) begin
            m_ovf = 1'b1;
            m_rej++;
        end
        if (accept) wcount++;
        m_full = (wcount - rcount) == DEPTH;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        w_en  = 1'b0;
        clr   = 1'b0;
        rptr  = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("reset");
    endtask

    initial begin
        model_reset();
        do_reset();

        // Fill an empty FIFO with the read pointer parked at zero.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, "fill");
        check("fill_gray_1100", 32'(g_wptr), 32'b1100);
        check("fill_level_8",   32'(wlevel), 32'd8);
        check("fill_full",      32'(full),   32'd1);

        // Writes attempted while full are rejected and counted.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "reject");
        check("reject_cnt_3", 32'(ovf_cnt), 32'd3);
        check("reject_b_frozen", 32'(b_wptr), 32'd8);
        step(1'b0, 1'b0, 1'b1, "clr");
        check("clr_cnt_0", 32'(ovf_cnt), 32'd0);

        // A clear in the same cycle as a rejected write takes priority.
        step(1'b1, 1'b0, 1'b0, "rej_before_clr");
        step(1'b1, 1'b0, 1'b1, "clr_vs_reject");
        check("clr_wins_ovf", 32'(ovf), 32'd0);

        // Five rejected writes saturate the 2-bit counter at 3.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, "sat");
        check("sat_cnt2_3", 32'(ovf_cnt2), 32'd3);
        check("sat_cnt_5",  32'(ovf_cnt),  32'd5);
        step(1'b0, 1'b0, 1'b1, "sat_clr");

        // One read releases full; one write makes it full again.
        step(1'b0, 1'b1, 1'b0, "read_one");
        check("release_full", 32'(full),   32'd0);
        check("release_lvl7", 32'(wlevel), 32'd7);
        step(1'b1, 1'b0, 1'b0, "refill");
        check("refill_full",  32'(full),   32'd1);

        // Simultaneous write and read leaves the level unchanged.
        step(1'b0, 1'b1, 1'b0, "pre_simul");
        step(1'b1, 1'b1, 1'b0, "simul");
        check("simul_lvl7", 32'(wlevel), 32'd7);

        // Randomized interleaved traffic across several pointer wraps:
        // write-heavy, balanced, then read-heavy phases.
        for (int i = 0; i < 600; i++) begin
            int wp, rp;
            wp = (i < 200) ? 75 : (i < 400) ? 50 : 25;
            rp = (i < 200) ? 40 : (i < 400) ? 50 : 80;
            step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                 $urandom_range(0, 99) < 4, "rand");
        end

        // Asynchronous reset in the middle of a cycle at level 5.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, "lvl5");
        check("lvl5_level", 32'(wlevel), 32'd5);
        w_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_b_wptr", 32'(b_wptr),   32'd0);
        check("arst_g_wptr", 32'(g_wptr),   32'd0);
        check("arst_full",   32'(full),     32'd0);
        check("arst_af",     32'(af),       32'd0);
        check("arst_wlevel", 32'(wlevel),   32'd0);
        check("arst_ovf",    32'(ovf),      32'd0);
        check("arst_cnt",    32'(ovf_cnt),  32'd0);
        check("arst_mem_we", 32'(mem_we),   32'd0);
        model_reset();
        rptr = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        w_en  = 1'b1;
        #1;
        check("post_rst_mem_we", 32'(mem_we), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
